// File: rtl/cmd_pkg.sv
// Shared definitions for the ground-link command sequencer: opcodes, frame header
// and the frame-decoder state encoding.
package cmd_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hEB;

  localparam logic [7:0] OPC_START = 8'h55;
  localparam logic [7:0] OPC_STOP  = 8'h5A;
  localparam logic [7:0] OPC_EXPO  = 8'hA5;
  localparam logic [7:0] OPC_RESET = 8'hAA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPC  = 2'd1,
    PAR  = 2'd2,
    CHK  = 2'd3
  } state_t;

  function automatic logic is_legal_opcode(input logic [7:0] op);
    return (op == OPC_START) || (op == OPC_STOP) || (op == OPC_EXPO) || (op == OPC_RESET);
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Turns a one-cycle trigger into a pulse PULSE_CYCLES wide; a trigger during an
// active pulse reloads the count so the output stays continuous.
module pulse_stretcher #(
  parameter int unsigned PULSE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic pulse
);

  localparam int unsigned CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(PULSE_CYCLES);

  logic [CW-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (trigger) begin
      count_q <= LOAD;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign pulse = (count_q != '0);

endmodule

// File: rtl/command_sequencer.sv
// Frames and validates HEADER/OPCODE/PARAM/CHK command bytes from the link receiver
// and drives capture enable, exposure load and the timed system-reset request.
module command_sequencer
  import cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES   = 1_000_000,
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter logic [7:0]  HEADER           = HEADER_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       command_latch,
  input  logic [7:0] command_data,
  output logic       capture_en,
  output logic [7:0] exposure_value,
  output logic       exposure_load,
  output logic       request_reset_signal,
  output logic       cmd_error,
  output logic       busy
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_next;
  logic [7:0]    opcode_q, param_q;
  logic [TW-1:0] timer_q;

  logic       capture_en_d, exposure_load_d, cmd_error_d, reset_trigger;
  logic [7:0] exposure_d;
  logic       timed_out;

  // Timer restarts on every byte and saturates so a long idle never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (command_latch) begin
      timer_q <= '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign timed_out = (state != IDLE) && !command_latch && (timer_q == TIMER_MAX);

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    capture_en_d    = capture_en;
    exposure_d      = exposure_value;
    exposure_load_d = 1'b0;
    cmd_error_d     = 1'b0;
    reset_trigger   = 1'b0;

    if (command_latch) begin
      unique case (state)
        IDLE: if (command_data == HEADER) state_next = OPC;
        OPC:  state_next = PAR;
        PAR:  state_next = CHK;
        CHK: begin
          state_next = IDLE;
          if ((command_data == (opcode_q ^ param_q)) && is_legal_opcode(opcode_q)) begin
            unique case (opcode_q)
              OPC_START: capture_en_d = 1'b1;
              OPC_STOP:  capture_en_d = 1'b0;
              OPC_EXPO: begin
                exposure_d      = param_q;
                exposure_load_d = 1'b1;
              end
              default: begin
                capture_en_d  = 1'b0;
                reset_trigger = 1'b1;
              end
            endcase
          end else begin
            cmd_error_d = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (timed_out) begin
      state_next  = IDLE;
      cmd_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      opcode_q       <= '0;
      param_q        <= '0;
      capture_en     <= 1'b0;
      exposure_value <= '0;
      exposure_load  <= 1'b0;
      cmd_error      <= 1'b0;
    end else begin
      state          <= state_next;
      capture_en     <= capture_en_d;
      exposure_value <= exposure_d;
      exposure_load  <= exposure_load_d;
      cmd_error      <= cmd_error_d;
      if (command_latch && state == OPC) opcode_q <= command_data;
      if (command_latch && state == PAR) param_q  <= command_data;
    end
  end

  assign busy = (state != IDLE);

  pulse_stretcher #(
    .PULSE_CYCLES(RST_PULSE_CYCLES)
  ) u_reset_pulse (
    .clk    (clk),
    .rst    (rst),
    .trigger(reset_trigger),
    .pulse  (request_reset_signal)
  );

endmodule

// File: tb/tb_command_sequencer.sv
// Self-checking bench for command_sequencer: directed scenarios plus random frames
// compared every cycle against a byte-stream reference model.
module tb_command_sequencer;

  localparam int T_OUT = 100;
  localparam int P_LEN = 16;
  localparam logic [7:0] HDR = 8'hEB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       command_latch = 1'b0;
  logic [7:0] command_data = 8'h00;
  logic       capture_en, exposure_load, request_reset_signal, cmd_error, busy;
  logic [7:0] exposure_value;

  int tests = 0;
  int failed = 0;

  command_sequencer #(
    .TIMEOUT_CYCLES  (T_OUT),
    .RST_PULSE_CYCLES(P_LEN),
    .HEADER          (HDR)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .command_latch       (command_latch),
    .command_data        (command_data),
    .capture_en          (capture_en),
    .exposure_value      (exposure_value),
    .exposure_load       (exposure_load),
    .request_reset_signal(request_reset_signal),
    .cmd_error           (cmd_error),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: collects frame bytes, applies whole commands
  logic [7:0] frame[$];
  int         gap = 0;
  logic       m_cap = 0, m_load = 0, m_err = 0;
  logic [7:0] m_expo = 0;
  int         m_rem = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        frame.delete();
        gap = 0; m_cap = 0; m_expo = 0; m_load = 0; m_err = 0; m_rem = 0;
      end else begin
        m_load = 0;
        m_err  = 0;
        if (m_rem > 0) m_rem--;
        if (command_latch) begin
          gap = 0;
          if (frame.size() != 0 || command_data == HDR) frame.push_back(command_data);
          if (frame.size() == 4) begin
            if (frame[3] == (frame[1] ^ frame[2]) && (frame[1] inside {8'h55, 8'h5A, 8'hA5, 8'hAA})) begin
              case (frame[1])
                8'h55: m_cap = 1;
                8'h5A: m_cap = 0;
                8'hA5: begin m_expo = frame[2]; m_load = 1; end
                default: begin m_cap = 0; m_rem = P_LEN; end
              endcase
            end else begin
              m_err = 1;
            end
            frame.delete();
          end
        end else begin
          if (gap < 1_000_000) gap++;
          if (frame.size() != 0 && gap >= T_OUT) begin
            m_err = 1;
            frame.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("capture_en", 32'(capture_en), 32'(m_cap));
      check("exposure_value", 32'(exposure_value), 32'(m_expo));
      check("exposure_load", 32'(exposure_load), 32'(m_load));
      check("cmd_error", 32'(cmd_error), 32'(m_err));
      check("request_reset", 32'(request_reset_signal), 32'(m_rem > 0));
      check("busy", 32'(busy), 32'(frame.size() != 0));
    end
  end

  // Width of the most recent completed reset pulse, in cycles.
  int run = 0;
  int last_width = 0;
  always @(negedge clk) begin
    if (rst) run <= 0;
    else if (request_reset_signal) run <= run + 1;
    else if (run > 0) begin
      last_width <= run;
      run <= 0;
    end
  end

  // ---------------- stimulus helpers; every task starts and ends at posedge+1
  task automatic send_byte(input logic [7:0] b);
    command_latch = 1'b1;
    command_data  = b;
    @(posedge clk); #1;
    command_latch = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] prm, input logic [7:0] chk);
    send_byte(HDR); send_byte(op); send_byte(prm); send_byte(chk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outputs"}, {26'd0, capture_en, exposure_load, request_reset_signal, cmd_error, busy,
                              |exposure_value}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] op, prm, chk;
    idle(3);
    check_all_zero("reset_state");
    rst = 1'b0;
    idle(2);

    // Start capture
    send_frame(8'h55, 8'h00, 8'h55);
    check("start_capture", 32'(capture_en), 32'd1);
    check("start_not_busy", 32'(busy), 32'd0);

    // Exposure load, then bad checksum keeps the old value
    send_frame(8'hA5, 8'h3C, 8'h99);
    check("expo_value", 32'(exposure_value), 32'h3C);
    check("expo_load_hi", 32'(exposure_load), 32'd1);
    idle(1);
    check("expo_load_lo", 32'(exposure_load), 32'd0);
    send_frame(8'hA5, 8'h3C, 8'h98);
    check("bad_chk_err", 32'(cmd_error), 32'd1);
    check("bad_chk_expo", 32'(exposure_value), 32'h3C);
    idle(1);
    check("bad_chk_err_once", 32'(cmd_error), 32'd0);

    // Reset request, then retrigger while the pulse is active
    send_frame(8'hAA, 8'h00, 8'hAA);
    check("reset_drops_capture", 32'(capture_en), 32'd0);
    check("reset_pulse_rises", 32'(request_reset_signal), 32'd1);
    idle(P_LEN + 4);
    check("reset_pulse_width", 32'(last_width), 32'd16);
    send_frame(8'hAA, 8'h00, 8'hAA);
    idle(6);
    send_frame(8'hAA, 8'h00, 8'hAA);
    idle(P_LEN + 4);
    check("retrigger_width", 32'(last_width), 32'd26);

    // Timeout after a partial frame
    send_byte(HDR); send_byte(8'h55);
    k = 0;
    for (int i = 1; i <= 3 * T_OUT; i++) begin
      @(posedge clk); #1;
      if (cmd_error) begin k = i; break; end
    end
    check("timeout_latency", 32'(k), 32'(T_OUT));
    check("timeout_not_busy", 32'(busy), 32'd0);
    send_frame(8'h55, 8'h00, 8'h55);
    check("after_timeout_frame", 32'(capture_en), 32'd1);

    // Stray bytes in IDLE, then an illegal opcode
    send_byte(8'h00); send_byte(8'hAA); send_byte(8'h12);
    check("stray_not_busy", 32'(busy), 32'd0);
    check("stray_capture", 32'(capture_en), 32'd1);
    send_frame(8'h77, 8'h00, 8'h77);
    check("illegal_opc_err", 32'(cmd_error), 32'd1);

    // Asynchronous reset mid-frame
    send_byte(HDR); send_byte(8'hA5);
    #3 rst = 1'b1;
    #1 check_all_zero("rst_mid_frame");
    @(posedge clk); #1 rst = 1'b0;

    // Asynchronous reset mid-pulse
    send_frame(8'hAA, 8'h00, 8'hAA);
    idle(3);
    #3 rst = 1'b1;
    #1 check_all_zero("rst_mid_pulse");
    @(posedge clk); #1 rst = 1'b0;
    idle(1);

    // Back-to-back frames with no idle cycle
    send_frame(8'h55, 8'h00, 8'h55);
    check("b2b_first", 32'(capture_en), 32'd1);
    send_frame(8'hA5, 8'h10, 8'hB5);
    check("b2b_second_expo", 32'(exposure_value), 32'h10);
    check("b2b_second_load", 32'(exposure_load), 32'd1);

    // Random traffic checked by the model
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: op = 8'h55;
        1: op = 8'h5A;
        2: op = 8'hA5;
        default: op = 8'hAA;
      endcase
      prm = 8'($urandom);
      chk = op ^ prm;
      if (kind == 0) chk = chk ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 1) op = 8'($urandom);
      if (kind == 2) begin
        send_byte(8'($urandom));
      end else if (kind == 3) begin
        send_byte(HDR);
        if ($urandom_range(0, 1) == 1) send_byte(op);
        idle(T_OUT + $urandom_range(0, 5));
      end else begin
        send_byte(HDR);   idle($urandom_range(0, 2));
        send_byte(op);    idle($urandom_range(0, 2));
        send_byte(prm);   idle($urandom_range(0, 2));
        send_byte(chk);
      end
      idle($urandom_range(0, 3));
    end
    idle(P_LEN + 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/command_sequencer.md
Name: command_sequencer

Overview:
- Frames and decodes ground-link command bytes delivered as a one-cycle `command_latch` strobe plus `command_data`.
- Validates each frame and sequences the capture datapath: capture enable, exposure load and a timed system-reset request.
- Sits between the link byte receiver and the CMOS capture / DDR3 / SDHC control logic.
- Replaces ad-hoc single-byte matching with framed, checksummed, timeout-protected commands.

Parameters:
- TIMEOUT_CYCLES, 1_000_000, maximum clk cycles allowed between bytes inside one frame.
- RST_PULSE_CYCLES, 16, width of `request_reset_signal` in clk cycles.
- HEADER, 8'hEB, frame start byte.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- command_latch  input  1  one-cycle strobe; `command_data` is valid in that cycle.
- command_data  input  8  command byte.
- capture_en  output  1  level; high while image capture is enabled.
- exposure_value  output  8  last accepted exposure setting.
- exposure_load  output  1  one-cycle pulse when `exposure_value` updates.
- request_reset_signal  output  1  reset request pulse, RST_PULSE_CYCLES wide.
- cmd_error  output  1  one-cycle pulse on checksum error, bad opcode or timeout.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (async, while `rst` is high):
  - All outputs 0; `exposure_value` = 0.
  - State = IDLE; timeout counter and pulse counter = 0.
- Frame format, 4 bytes: HEADER, OPCODE, PARAM, CHK, where CHK = OPCODE ^ PARAM.
- Opcodes:
  - 8'h55: start capture.
  - 8'h5A: stop capture.
  - 8'hA5: set exposure to PARAM.
  - 8'hAA: reset request.
  - PARAM is ignored by every opcode except A5, but it is still covered by CHK.
- FSM states and transitions (transitions occur only on cycles with `command_latch` = 1, except timeout):
  - IDLE: byte == HEADER -> OPC; any other byte is discarded silently, no error.
  - OPC: store the byte as the opcode -> PAR.
  - PAR: store the byte as the parameter -> CHK.
  - CHK: byte == opcode ^ param and opcode is legal -> execute; otherwise pulse `cmd_error`. Return to IDLE in both cases.
- Execute latency: outputs update on the clk edge following the CHK-byte latch cycle. That is one cycle after the latch is sampled.
- Command effects:
  - 55: `capture_en` <= 1; no effect if already 1.
  - 5A: `capture_en` <= 0.
  - A5: `exposure_value` <= PARAM and `exposure_load` = 1 for one cycle. `capture_en` is unchanged.
  - AA: `capture_en` <= 0 in the same cycle; `request_reset_signal` rises in the same cycle and stays high exactly RST_PULSE_CYCLES cycles.
  - AA received while a reset pulse is already active restarts the count; the pulse stays continuous.
- Timeout:
  - The counter clears on every latch.
  - In OPC, PAR or CHK, reaching TIMEOUT_CYCLES-1 without a latch gives state -> IDLE and `cmd_error` pulses once.
  - If a latch arrives in the same cycle as expiry, the latch wins and no timeout occurs.
- A HEADER byte arriving in OPC, PAR or CHK is treated as data, not as a resync. Recovery is via checksum error or timeout.
- After CHK the FSM is in IDLE, so a latch on the very next cycle is accepted as a new header. Back-to-back frames need no gap.
- `cmd_error` and `exposure_load` never assert in the same cycle.
- Counter widths are sized with clog2 of the parameters. The timeout counter saturates and never wraps.
- `rst` asserted mid-frame or mid-pulse aborts everything immediately. This includes dropping `request_reset_signal`.

Decomposition:
- Shared package `cmd_pkg`:
  - Opcode constants OPC_START, OPC_STOP, OPC_EXPO and OPC_RESET.
  - HEADER default.
  - FSM state encoding (IDLE/OPC/PAR/CHK, 2 bits).
- One sub-module, `pulse_stretcher`:
  - Loadable down-counter that generates `request_reset_signal` from a one-cycle trigger.
  - Re-trigger restarts the count.
- The FSM, timeout counter and output registers stay in the top module.

Test Plan:
- Send EB,55,00,55 -> `capture_en` rises one cycle after the last latch. `cmd_error` stays 0 and `busy` returns to 0.
- Send EB,A5,3C,99 -> `exposure_value` = 8'h3C with a single-cycle `exposure_load`. Then send EB,A5,3C,98 -> `cmd_error` pulses once and `exposure_value` remains 8'h3C.
- With `capture_en` = 1, send EB,AA,00,AA -> `capture_en` drops to 0 and `request_reset_signal` is high exactly 16 cycles. Resend the frame at pulse cycle 10 -> the pulse stays continuous for 10+16 cycles total.
- Send EB,55 and then no further latch -> `cmd_error` pulses exactly TIMEOUT_CYCLES (set to 100 for the test) cycles after the last latch. `busy` drops, and a following valid frame executes normally.
- Send stray bytes 00,AA,12 in IDLE -> no output change and no error. Send EB,77,00,77 (illegal opcode) -> `cmd_error` pulses once.
- Assert `rst` mid-frame and mid-reset-pulse -> all outputs go to 0 immediately. Send two back-to-back frames with no idle cycle (55 frame, then A5/0x10 frame) -> both execute correctly.
